// File: rtl/temp_seg_display.sv
// Binary-to-BCD (sequential double-dabble) converter driving a four-digit, active-low,
// time-multiplexed seven-segment display: hundreds, tens, ones, then the unit letter.
module temp_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] value,
    input  logic       unit,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegC     = 7'b1000110;
    localparam logic [6:0] SegF     = 7'b0001110;

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e      state_q, state_d;
    logic [6:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [2:0]  iter_q, iter_d;
    logic        unit_q, unit_d;
    logic        commit;

    logic [3:0]  disp_h_q, disp_t_q, disp_o_q;
    logic        disp_unit_q;

    logic [CntW-1:0] ref_cnt_q;
    logic [1:0]      idx_q;
    logic [6:0]      seg_d;
    logic [3:0]      an_d;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    assign busy = (state_q != StIdle);

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        unit_d  = unit_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d   = value;
                    unit_d  = unit;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
                iter_d         = iter_q + 3'd1;
                if (iter_q == 3'd6) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            unit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            unit_q  <= unit_d;
        end
    end

    // Display registers change only on commit, so partial results are never shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_h_q    <= '0;
            disp_t_q    <= '0;
            disp_o_q    <= '0;
            disp_unit_q <= 1'b0;
        end else if (commit) begin
            disp_h_q    <= bcd_q[11:8];
            disp_t_q    <= bcd_q[7:4];
            disp_o_q    <= bcd_q[3:0];
            disp_unit_q <= unit_q;
        end
    end

    always_comb begin
        seg_d = SegBlank;
        an_d  = ~(4'b0001 << idx_q);
        unique case (idx_q)
            2'd3: seg_d = (disp_h_q == 4'd0) ? SegBlank : digit_seg(disp_h_q);
            2'd2: seg_d = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? SegBlank
                                                                 : digit_seg(disp_t_q);
            2'd1: seg_d = digit_seg(disp_o_q);
            2'd0: seg_d = disp_unit_q ? SegF : SegC;
            default: seg_d = SegBlank;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= 2'd3;
            seg       <= SegBlank;
            an        <= 4'b1111;
        end else begin
            if (ref_cnt_q == CntMax) begin
                ref_cnt_q <= '0;
                idx_q     <= idx_q - 2'd1;
            end else begin
                ref_cnt_q <= ref_cnt_q + CntW'(1);
            end
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule
